// File: rtl/dircc_node_mem_port_arbiter.sv
// Round-robin arbiter sharing memory port B between receive (m0) and transmit (m1) DMA masters.
// Grant is combinational from last_grant/hold_cnt/lock state; read data returns one cycle after accept.
module dircc_node_mem_port_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int BE_W     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

  logic            req0, req1;
  logic            gnt1, accept, acc0, acc1;
  logic            last_grant;
  logic [HC_W-1:0] hold_cnt, hold_next;
  logic            lock_vld, lock_owner;
  logic            rd_pend0, rd_pend1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // When both request, the other master is always requesting too, so the lock
  // only yields once the owner has used up its hold budget.
  always_comb begin
    gnt1 = 1'b0;
    if (req1 && !req0) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      if (lock_vld && (hold_cnt < HOLD_MAX)) gnt1 = lock_owner;
      else                                   gnt1 = ~last_grant;
    end
  end

  assign accept = (gnt1 ? req1 : req0) & ~freeze & reset_n;
  assign acc0   = accept & ~gnt1;
  assign acc1   = accept & gnt1;

  assign m0_waitrequest = req0 & ~acc0;
  assign m1_waitrequest = req1 & ~acc1;

  assign mem_address    = gnt1 ? m1_address    : m0_address;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_chipselect = accept;
  assign mem_write      = accept & (gnt1 ? m1_write : m0_write);
  assign mem_clken      = ~freeze;

  always_comb begin
    hold_next = HC_W'(1);
    if (gnt1 == last_grant)
      hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      hold_cnt   <= '0;
      lock_vld   <= 1'b0;
      lock_owner <= 1'b0;
      rd_pend0   <= 1'b0;
      rd_pend1   <= 1'b0;
    end else begin
      rd_pend0 <= acc0 & m0_read & ~m0_write;
      rd_pend1 <= acc1 & m1_read & ~m1_write;
      if (accept) begin
        last_grant <= gnt1;
        lock_vld   <= gnt1 ? m1_lock : m0_lock;
        lock_owner <= gnt1;
        hold_cnt   <= hold_next;
      end
    end
  end

  // Port B returns data for the registered address, shared by both masters.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend0 & reset_n;
  assign m1_readdatavalid = rd_pend1 & reset_n;

endmodule

// File: tb/tb_dircc_node_mem_port_arbiter.sv
// Scoreboard bench for dircc_node_mem_port_arbiter: masters replay op queues, a negedge
// monitor checks accept order and read returns against hand-computed expectations.
module tb_dircc_node_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n, freeze;
  logic [14:0] m0_address, m1_address;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [15:0] m0_writedata, m1_writedata;
  logic [1:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [15:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [14:0] mem_address;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_writedata, mem_readdata;
  logic        mem_chipselect, mem_write, mem_clken;

  always #5 clk = ~clk;

  dircc_node_mem_port_arbiter #(.ADDR_W(15), .DATA_W(16), .BE_W(2), .MAX_HOLD(4)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // Port B model: registered address, unregistered data, byte-enabled writes.
  logic [15:0] mem [0:255];
  logic [14:0] addr_q;
  initial begin
    addr_q <= '0;
    for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 + 16'(i);
  end
  always @(posedge clk) begin
    if (mem_clken) begin
      addr_q <= mem_address;
      if (mem_chipselect && mem_write) begin
        if (mem_byteenable[0]) mem[mem_address[7:0]][7:0]  <= mem_writedata[7:0];
        if (mem_byteenable[1]) mem[mem_address[7:0]][15:8] <= mem_writedata[15:8];
      end
    end
  end
  assign mem_readdata = mem[addr_q[7:0]];

  typedef struct { logic rd; logic wr; logic lock; logic [14:0] addr; logic [15:0] data; logic [1:0] be; } op_t;
  typedef struct { logic m; logic [14:0] addr; logic wr; logic [15:0] data; logic [1:0] be; } acc_t;
  typedef struct { logic m; logic [15:0] data; } rd_t;

  op_t  q0[$], q1[$];
  acc_t exp_acc[$];
  rd_t  exp_rd[$];
  int   lat_q[$];
  int   tests = 0, fails = 0, cyc = 0;
  logic acc0 = 1'b0, acc1 = 1'b0;

  always @(negedge clk) begin
    acc_t e;
    rd_t  r;
    logic mv;
    logic [15:0] rdat;
    int   l;
    cyc++;
    if (!reset_n) begin
      acc0 = 1'b0;
      acc1 = 1'b0;
    end else begin
      acc0 = (m0_read | m0_write) & ~m0_waitrequest;
      acc1 = (m1_read | m1_write) & ~m1_waitrequest;
      if (mem_chipselect) begin
        tests++;
        if (exp_acc.size() == 0 || acc0 == acc1) begin
          fails++;
          $display("FAIL accept: unexpected accept addr=%h acc0=%b acc1=%b pending=%0d", mem_address, acc0, acc1, exp_acc.size());
        end else begin
          e = exp_acc.pop_front();
          if (acc1 !== e.m || mem_address !== e.addr || mem_write !== e.wr ||
              (e.wr && (mem_writedata !== e.data || mem_byteenable !== e.be))) begin
            fails++;
            $display("FAIL accept: got m%0d addr=%h wr=%b data=%h be=%b, expected m%0d addr=%h wr=%b data=%h be=%b",
                     acc1, mem_address, mem_write, mem_writedata, mem_byteenable, e.m, e.addr, e.wr, e.data, e.be);
          end
        end
        if (!mem_write) lat_q.push_back(cyc);
      end
      if (m0_readdatavalid || m1_readdatavalid) begin
        tests++;
        mv   = m1_readdatavalid;
        rdat = mv ? m1_readdata : m0_readdata;
        if (exp_rd.size() == 0 || (m0_readdatavalid && m1_readdatavalid)) begin
          fails++;
          $display("FAIL readdata: unexpected return v0=%b v1=%b data=%h", m0_readdatavalid, m1_readdatavalid, rdat);
        end else begin
          r = exp_rd.pop_front();
          if (mv !== r.m || rdat !== r.data) begin
            fails++;
            $display("FAIL readdata: got m%0d %h, expected m%0d %h", mv, rdat, r.m, r.data);
          end
        end
        tests++;
        l = (lat_q.size() > 0) ? lat_q.pop_front() : -10;
        if (cyc != l + 1) begin
          fails++;
          $display("FAIL rd_latency: return at cycle %0d, expected %0d", cyc, l + 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin
      m0_read = q0[0].rd; m0_write = q0[0].wr; m0_lock = q0[0].lock;
      m0_address = q0[0].addr; m0_writedata = q0[0].data; m0_byteenable = q0[0].be;
    end else begin
      m0_read = 1'b0; m0_write = 1'b0; m0_lock = 1'b0;
      m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    end
    if (q1.size() > 0) begin
      m1_read = q1[0].rd; m1_write = q1[0].wr; m1_lock = q1[0].lock;
      m1_address = q1[0].addr; m1_writedata = q1[0].data; m1_byteenable = q1[0].be;
    end else begin
      m1_read = 1'b0; m1_write = 1'b0; m1_lock = 1'b0;
      m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] wdata(input logic m, input logic [14:0] a);
    return (m ? 16'hB000 : 16'hA000) + {1'b0, a};
  endfunction

  task automatic op(input logic m, input logic rd, input logic wr, input logic lock,
                    input logic [14:0] a, input logic [15:0] d, input logic [1:0] be);
    op_t o;
    o.rd = rd; o.wr = wr; o.lock = lock; o.addr = a; o.data = d; o.be = be;
    if (m) q1.push_back(o); else q0.push_back(o);
  endtask

  task automatic wr_op(input logic m, input logic [14:0] a, input logic lock);
    op(m, 1'b0, 1'b1, lock, a, wdata(m, a), 2'b11);
  endtask

  task automatic ex_acc(input logic m, input logic [14:0] a, input logic wr, input logic [15:0] d, input logic [1:0] be);
    acc_t e;
    e.m = m; e.addr = a; e.wr = wr; e.data = d; e.be = be;
    exp_acc.push_back(e);
  endtask

  task automatic ex_wr(input logic m, input logic [14:0] a);
    ex_acc(m, a, 1'b1, wdata(m, a), 2'b11);
  endtask

  task automatic ex_rd(input logic m, input logic [14:0] a, input logic [15:0] d);
    rd_t r;
    ex_acc(m, a, 1'b0, 16'h0, 2'b00);
    r.m = m; r.data = d;
    exp_rd.push_back(r);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() + q1.size() + exp_acc.size() + exp_rd.size()) > 0 && n < 40) begin
      step();
      n++;
    end
    step();
    step();
    tests++;
    if (n >= 40) begin
      fails++;
      $display("FAIL %s: timeout, left q0=%0d q1=%0d acc=%0d rd=%0d", name, q0.size(), q1.size(), exp_acc.size(), exp_rd.size());
      q0.delete(); q1.delete(); exp_acc.delete(); exp_rd.delete(); lat_q.delete();
    end
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    freeze  = 1'b0;
    step();
    step();

    // Reset with both masters reading, then release: m0 wins the first tie.
    op(1'b0, 1'b1, 1'b0, 1'b0, 15'h0020, 16'h0, 2'b11);
    op(1'b1, 1'b1, 1'b0, 1'b0, 15'h0021, 16'h0, 2'b11);
    step();
    #2;
    chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    chk("rst_cs", 32'(mem_chipselect), 32'd0);
    chk("rst_rdvalid", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
    ex_rd(1'b0, 15'h0020, 16'hC020);
    ex_rd(1'b1, 15'h0021, 16'hC021);
    reset_n = 1'b1;
    drain("reset_release");

    // Single m0 read: accepted in the same cycle.
    op(1'b0, 1'b1, 1'b0, 1'b0, 15'h0010, 16'h0, 2'b11);
    ex_rd(1'b0, 15'h0010, 16'hC010);
    step();
    #2;
    chk("single_wait", 32'(m0_waitrequest), 32'd0);
    chk("single_addr", 32'(mem_address), 32'h0010);
    drain("single_read");

    // Continuous writes from both, no lock: strict alternation from m0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_op(1'b0, 15'h0040 + 15'(i), 1'b0);
      wr_op(1'b1, 15'h0050 + 15'(i), 1'b0);
      ex_wr(1'b0, 15'h0040 + 15'(i));
      ex_wr(1'b1, 15'h0050 + 15'(i));
    end
    drain("round_robin");

    // Locked m0 keeps the port for MAX_HOLD=4 transfers, then yields once.
    do_reset();
    for (int i = 0; i < 6; i++) wr_op(1'b0, 15'h0060 + 15'(i), 1'b1);
    wr_op(1'b1, 15'h0070, 1'b0);
    wr_op(1'b1, 15'h0071, 1'b0);
    for (int i = 0; i < 4; i++) ex_wr(1'b0, 15'h0060 + 15'(i));
    ex_wr(1'b1, 15'h0070);
    ex_wr(1'b0, 15'h0064);
    ex_wr(1'b0, 15'h0065);
    ex_wr(1'b1, 15'h0071);
    drain("lock_hold");

    // Freeze for three cycles in mid contention; order resumes unchanged.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_op(1'b0, 15'h0080 + 15'(i), 1'b0);
      wr_op(1'b1, 15'h0090 + 15'(i), 1'b0);
      ex_wr(1'b0, 15'h0080 + 15'(i));
      ex_wr(1'b1, 15'h0090 + 15'(i));
    end
    step();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      freeze = 1'b1;
      #2;
      chk("frz_cs", 32'(mem_chipselect), 32'd0);
      chk("frz_clken", 32'(mem_clken), 32'd0);
      chk("frz_waits", 32'({m0_waitrequest, m1_waitrequest}), 32'b11);
    end
    step();
    freeze = 1'b0;
    drain("freeze");

    // Interleaved reads around a partial-byte write from m1.
    op(1'b0, 1'b1, 1'b0, 1'b0, 15'h0040, 16'h0, 2'b11);
    op(1'b0, 1'b1, 1'b0, 1'b0, 15'h0044, 16'h0, 2'b11);
    op(1'b1, 1'b0, 1'b1, 1'b0, 15'h0044, 16'h1234, 2'b10);
    op(1'b1, 1'b1, 1'b0, 1'b0, 15'h0051, 16'h0, 2'b11);
    ex_rd(1'b0, 15'h0040, 16'hA040);
    ex_acc(1'b1, 15'h0044, 1'b1, 16'h1234, 2'b10);
    ex_rd(1'b0, 15'h0044, 16'h1244);
    ex_rd(1'b1, 15'h0051, 16'hB051);
    drain("interleave");

    // Read and write together behaves as a write with no data returned.
    op(1'b0, 1'b1, 1'b1, 1'b0, 15'h0046, 16'h5555, 2'b11);
    ex_acc(1'b0, 15'h0046, 1'b1, 16'h5555, 2'b11);
    op(1'b1, 1'b1, 1'b0, 1'b0, 15'h0046, 16'h0, 2'b11);
    ex_rd(1'b1, 15'h0046, 16'h5555);
    drain("rd_and_wr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
